// File: rtl/otter_mem_arb_pkg.sv
// Shared types and constants for the OTTER memory port-2 arbiter.
package otter_mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR_ISSUE,
        DONE
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

    localparam int          LINE_WORDS = 4;
    localparam int          LINE_W     = LINE_WORDS * 32;
    localparam logic [31:0] IO_BASE    = 32'h1100_0000;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // MMIO space bypasses the line path and returns the sliced port value.
    function automatic logic is_uncached(input logic [31:0] addr);
        return addr >= IO_BASE;
    endfunction

endpackage

// File: rtl/otter_mem_arbiter_rr_arbiter2.sv
// Two-way grant between I-refill and D requests.
// OTTER_MEM_ARB_RR_EN selects round-robin; otherwise D has fixed priority.
module rr_arbiter2
    import otter_mem_arb_pkg::*;
(
`ifdef OTTER_MEM_ARB_RR_EN
    input  logic CLK,
    input  logic RST,
    input  logic upd,
    input  logic i_req,
`endif
    input  logic d_req,
    output logic gnt_d
);

`ifdef OTTER_MEM_ARB_RR_EN
    owner_t last_gnt;

    // On a tie the side not granted last wins; a lone request always wins.
    always_comb begin
        gnt_d = 1'b0;
        if (d_req && (!i_req || last_gnt == OWN_I))
            gnt_d = 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            last_gnt <= OWN_I;
        else if (upd)
            last_gnt <= gnt_d ? OWN_D : OWN_I;
    end
`else
    assign gnt_d = d_req;
`endif

endmodule

// File: rtl/otter_mem_arbiter.sv
// Shares OTTER memory port 2 between I-refill and D-cache, one transaction at a time.
// Define OTTER_MEM_ARB_RR_EN for round-robin tie-breaking (default: D priority).
module otter_mem_arbiter
    import otter_mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [127:0]      i_line,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [1:0]        d_size,
    input  logic              d_sign,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [127:0]      d_line,
    output logic [ADDR_W-1:0] mem_addr2,
    output logic [31:0]       mem_din2,
    output logic              mem_write2,
    output logic              mem_read2,
    output logic [1:0]        mem_size,
    output logic              mem_sign,
    input  logic [31:0]       mem_r0,
    input  logic [31:0]       mem_r1,
    input  logic [31:0]       mem_r2,
    input  logic [31:0]       mem_r3,
    input  logic [31:0]       mem_dout2
);

    arb_state_t        state;
    owner_t            owner;
    logic              uc_q;
    logic              gnt_d;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_wr;
    logic              sel_uc;
    logic              sel_line;
    logic [LINE_W-1:0] rd_line;

    rr_arbiter2 u_arb (
`ifdef OTTER_MEM_ARB_RR_EN
        .CLK   (CLK),
        .RST   (RST),
        .upd   (state == IDLE && (i_req || d_req)),
        .i_req (i_req),
`endif
        .d_req (d_req),
        .gnt_d (gnt_d)
    );

    always_comb begin
        sel_addr = gnt_d ? d_addr : i_addr;
        sel_wr   = gnt_d && d_we;
        sel_uc   = gnt_d && !d_we && is_uncached(32'(d_addr));
        sel_line = !sel_wr && !sel_uc;
    end

    // Uncached results are zero-extended into the low word of the line.
    always_comb begin
        rd_line = '0;
        if (uc_q)
            rd_line[31:0] = mem_dout2;
        else
            rd_line = {mem_r3, mem_r2, mem_r1, mem_r0};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            owner      <= OWN_I;
            uc_q       <= 1'b0;
            mem_addr2  <= '0;
            mem_din2   <= '0;
            mem_size   <= SZ_WORD;
            mem_sign   <= 1'b0;
            mem_read2  <= 1'b0;
            mem_write2 <= 1'b0;
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
            i_line     <= '0;
            d_line     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        owner     <= gnt_d ? OWN_D : OWN_I;
                        uc_q      <= sel_uc;
                        mem_addr2 <= sel_line ? {sel_addr[ADDR_W-1:4], 4'b0} : sel_addr;
                        mem_size  <= sel_line ? SZ_WORD : d_size;
                        mem_sign  <= sel_line ? 1'b0 : d_sign;
                        mem_din2  <= gnt_d ? d_wdata : 32'h0;
                        if (sel_wr) begin
                            mem_write2 <= 1'b1;
                            state      <= WR_ISSUE;
                        end else begin
                            mem_read2 <= 1'b1;
                            state     <= RD_ISSUE;
                        end
                    end
                end
                RD_ISSUE: begin
                    mem_read2 <= 1'b0;
                    state     <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (owner == OWN_D) begin
                        d_line <= rd_line;
                        d_ack  <= 1'b1;
                    end else begin
                        i_line <= rd_line;
                        i_ack  <= 1'b1;
                    end
                    state <= DONE;
                end
                WR_ISSUE: begin
                    mem_write2 <= 1'b0;
                    d_ack      <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    i_ack <= 1'b0;
                    d_ack <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Self-checking bench for otter_mem_arbiter: vector table plus multi-cycle corner sequences.
module tb_otter_mem_arbiter;
    import otter_mem_arb_pkg::*;

    logic         CLK = 1'b0;
    logic         RST;
    logic         i_req, d_req, d_we, d_sign;
    logic [31:0]  i_addr, d_addr, d_wdata;
    logic [1:0]   d_size;
    logic         i_ack, d_ack;
    logic [127:0] i_line, d_line;
    logic [31:0]  mem_addr2, mem_din2;
    logic         mem_write2, mem_read2, mem_sign;
    logic [1:0]   mem_size;
    logic [31:0]  mem_r0, mem_r1, mem_r2, mem_r3, mem_dout2;

    always #5 CLK = ~CLK;

    otter_mem_arbiter dut (
        .CLK(CLK), .RST(RST),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_line(i_line),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_size(d_size), .d_sign(d_sign),
        .d_wdata(d_wdata), .d_ack(d_ack), .d_line(d_line),
        .mem_addr2(mem_addr2), .mem_din2(mem_din2), .mem_write2(mem_write2),
        .mem_read2(mem_read2), .mem_size(mem_size), .mem_sign(mem_sign),
        .mem_r0(mem_r0), .mem_r1(mem_r1), .mem_r2(mem_r2), .mem_r3(mem_r3),
        .mem_dout2(mem_dout2)
    );

    typedef struct {
        logic        is_d, we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] wdata, r0, r1, r2, r3, dout, exp_addr;
        logic [1:0]  exp_size;
        logic        exp_sign, exp_uc;
    } vec_t;

    typedef struct {
        logic         is_d;
        logic         chk_line;
        logic [127:0] line;
    } exp_t;

    exp_t         sb[$];
    vec_t         vecs[8];
    logic [127:0] exp_iline, exp_dline;
    int           errors = 0;
    int           checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_ack();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: unexpected ack i=%b d=%b", i_ack, d_ack);
        end else begin
            e = sb.pop_front();
            chk("ack_owner", {i_ack, d_ack}, e.is_d ? 2'b01 : 2'b10);
            if (e.chk_line) begin
                if (e.is_d) exp_dline = e.line;
                else        exp_iline = e.line;
                chk("line", e.is_d ? d_line : i_line, e.line);
            end
        end
    endtask

    task automatic do_reset();
        i_req = 1'b0;
        d_req = 1'b0;
        RST   = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        exp_iline = '0;
        exp_dline = '0;
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   n, rd, wr;
        bit   got;
        mem_r0 = v.r0; mem_r1 = v.r1; mem_r2 = v.r2; mem_r3 = v.r3; mem_dout2 = v.dout;
        e.is_d     = v.is_d;
        e.chk_line = !v.we;
        e.line     = v.exp_uc ? {96'b0, v.dout} : {v.r3, v.r2, v.r1, v.r0};
        sb.push_back(e);
        if (v.is_d) begin
            d_we = v.we; d_addr = v.addr; d_size = v.size; d_sign = v.sign; d_wdata = v.wdata;
            d_req = 1'b1;
        end else begin
            i_addr = v.addr;
            i_req  = 1'b1;
        end
        n = 0; rd = 0; wr = 0; got = 0;
        while (!got && n < 10) begin
            @(posedge CLK);
            @(negedge CLK);
            n++;
            if (mem_read2) begin
                rd++;
                chk("rd_addr", mem_addr2, v.exp_addr);
                chk("rd_size", mem_size, v.exp_size);
                chk("rd_sign", mem_sign, v.exp_sign);
            end
            if (mem_write2) begin
                wr++;
                chk("wr_addr", mem_addr2, v.exp_addr);
                chk("wr_size", mem_size, v.exp_size);
                chk("wr_data", mem_din2, v.wdata);
            end
            if (i_ack || d_ack) begin
                got   = 1;
                i_req = 1'b0;
                d_req = 1'b0;
                check_ack();
                chk("ack_latency", n, v.we ? 2 : 3);
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: no ack after %0d cycles, required one", n);
            i_req = 1'b0;
            d_req = 1'b0;
        end
        chk("rd_strobes", rd, v.we ? 0 : 1);
        chk("wr_strobes", wr, v.we ? 1 : 0);
        @(posedge CLK);
        @(negedge CLK);
        chk("ack_cleared", {i_ack, d_ack}, 2'b00);
        chk("i_line_hold", i_line, exp_iline);
        chk("d_line_hold", d_line, exp_dline);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n, got, acks, wrs, rds;
        vec_t wv;

        //          is_d  we    addr            size   sign  wdata          r0      r1      r2      r3      dout           exp_addr        exp_sz exp_sg exp_uc
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0104, 2'd2, 1'b0, 32'h0,        32'd1,  32'd2,  32'd3,  32'd4,  32'h0,         32'h0000_0100, 2'd2, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0200, 2'd0, 1'b0, 32'hAB,       32'h0,  32'h0,  32'h0,  32'h0,  32'h0,         32'h0000_0200, 2'd0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_02A7, 2'd0, 1'b1, 32'h0,        32'd5,  32'd6,  32'd7,  32'd8,  32'hEE,        32'h0000_02A0, 2'd2, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 32'h1100_0000, 2'd2, 1'b0, 32'h0,        32'd9,  32'd9,  32'd9,  32'd9,  32'h5A,        32'h1100_0000, 2'd2, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 32'h1100_0003, 2'd0, 1'b1, 32'h0,        32'd1,  32'd1,  32'd1,  32'd1,  32'hFFFF_FF80, 32'h1100_0003, 2'd0, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 32'h1100_0010, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0,  32'h0,  32'h0,  32'h0,  32'h0,         32'h1100_0010, 2'd2, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 32'h0000_03FC, 2'd0, 1'b1, 32'h0,        32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'h0,         32'h0000_03F0, 2'd2, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 32'h10FF_FFFC, 2'd2, 1'b0, 32'h0,        32'h11, 32'h22, 32'h33, 32'h44, 32'h77,        32'h10FF_FFF0, 2'd2, 1'b0, 1'b0};

        i_addr = '0; d_we = 1'b0; d_addr = '0; d_size = 2'd2; d_sign = 1'b0; d_wdata = '0;
        mem_r0 = '0; mem_r1 = '0; mem_r2 = '0; mem_r3 = '0; mem_dout2 = '0;
        do_reset();

        chk("rst_strobes", {mem_read2, mem_write2, i_ack, d_ack}, 4'b0000);
        chk("rst_lines", {i_line, d_line}, 256'h0);
        chk("rst_addr_din", {mem_addr2, mem_din2}, 64'h0);
        chk("rst_size_sign", {mem_size, mem_sign}, 3'b100);

        for (int k = 0; k < 8; k++)
            run_vec(vecs[k]);

        // Simultaneous held requests from a fresh reset.
        do_reset();
        mem_r0 = 32'hC0; mem_r1 = 32'hC1; mem_r2 = 32'hC2; mem_r3 = 32'hC3; mem_dout2 = 32'h0;
        d_we = 1'b0; d_addr = 32'h300; d_size = 2'd2; d_sign = 1'b0; i_addr = 32'h500;
        for (int k = 0; k < 4; k++) begin
`ifdef OTTER_MEM_ARB_RR_EN
            e.is_d = (k % 2 == 0);
`else
            e.is_d = 1'b1;
`endif
            e.chk_line = 1'b1;
            e.line     = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
            sb.push_back(e);
        end
        i_req = 1'b1;
        d_req = 1'b1;
        n = 0; got = 0;
        while (got < 4 && n < 40) begin
            @(posedge CLK);
            @(negedge CLK);
            n++;
            if (i_ack || d_ack) begin
                got++;
                check_ack();
            end
        end
        if (got < 4) begin
            checks++;
            errors++;
            $display("FAIL arb_timeout: got %0d acks, required 4", got);
        end
        i_req = 1'b0;
        d_req = 1'b0;
        repeat (4) begin
            @(posedge CLK);
            @(negedge CLK);
        end
        chk("arb_sb_drained", sb.size(), 0);
        chk("arb_i_line", i_line, exp_iline);

        // Reset while a write strobe is on the port.
        d_we = 1'b1; d_addr = 32'h240; d_size = 2'd1; d_sign = 1'b0; d_wdata = 32'h1234;
        d_req = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        chk("wr_issue_strobe", mem_write2, 1'b1);
        #2 RST = 1'b1;
        #1;
        chk("rst_wr_drop", mem_write2, 1'b0);
        chk("rst_no_ack", d_ack, 1'b0);
        chk("rst_size_mid", mem_size, 2'd2);
        @(posedge CLK);
        @(negedge CLK);
        chk("rst_hold_no_ack", {d_ack, mem_write2, mem_addr2}, 34'h0);
        RST = 1'b0;
        exp_iline = '0;
        exp_dline = '0;
        wv = '{1'b1, 1'b1, 32'h240, 2'd1, 1'b0, 32'h1234, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
               32'h240, 2'd1, 1'b0, 1'b0};
        run_vec(wv);

        // Requester withdraws right after grant.
        e.is_d = 1'b1; e.chk_line = 1'b0; e.line = '0;
        sb.push_back(e);
        d_we = 1'b1; d_addr = 32'h280; d_size = 2'd2; d_wdata = 32'h5555_AAAA;
        d_req = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        d_req = 1'b0;
        wrs = mem_write2 ? 1 : 0;
        rds = mem_read2 ? 1 : 0;
        acks = 0;
        repeat (6) begin
            @(posedge CLK);
            @(negedge CLK);
            if (mem_write2) wrs++;
            if (mem_read2) rds++;
            if (d_ack || i_ack) begin
                acks++;
                check_ack();
            end
        end
        chk("drop_ack_count", acks, 1);
        chk("drop_wr_count", wrs, 1);
        chk("drop_rd_count", rds, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
